axisr_rr_mux: RTL and testbench

- Parametrised N-to-1 mux for routed AXI4 streams, with round-robin arbitration at packet granularity.
- Successor to the fixed single-channel routed-stream path.
- Generalised in channel count, data width and ID width.
- Adds packet-locked grants, optional source tagging into tid, and a registered output stage.
- Sits between per-vFPGA/per-queue producers and a shared stream consumer (e.g. host or network TX).

---
 rtl/axisr_rr_mux.sv | 187 ++++++++++++++++++
 tb/tb_axisr_rr_mux.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axisr_rr_mux.sv
// N-to-1 routed AXI4-Stream mux with packet-locked round-robin arbitration and a registered output stage.
// Optional per-channel packet/beat counters are built when AXISR_RR_MUX_STATS_EN is defined.
module axisr_rr_mux #(
  parameter int unsigned N_CHAN    = 4,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned ID_BITS   = 6,
  parameter int unsigned TAG_SRC   = 0
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [N_CHAN-1:0]                 s_tvalid,
  output logic [N_CHAN-1:0]                 s_tready,
  input  logic [N_CHAN*DATA_BITS-1:0]       s_tdata,
  input  logic [N_CHAN*(DATA_BITS/8)-1:0]   s_tkeep,
  input  logic [N_CHAN-1:0]                 s_tlast,
  input  logic [N_CHAN*ID_BITS-1:0]         s_tid,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_BITS-1:0]              m_tdata,
  output logic [DATA_BITS/8-1:0]            m_tkeep,
  output logic                              m_tlast,
  output logic [ID_BITS-1:0]                m_tid
`ifdef AXISR_RR_MUX_STATS_EN
  ,
  output logic [N_CHAN*32-1:0]              stat_pkt_cnt,
  output logic [N_CHAN*32-1:0]              stat_beat_cnt
`endif
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned GW        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned LAST_CH   = N_CHAN - 1;

  if (N_CHAN < 2 || N_CHAN > 16) begin : g_bad_nchan
    $error("axisr_rr_mux: N_CHAN must be in 2..16");
  end
  if (TAG_SRC != 0 && ID_BITS < $clog2(N_CHAN)) begin : g_bad_tag
    $error("axisr_rr_mux: ID_BITS too narrow to carry the source channel index");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        w_grant_nxt;
  logic [GW-1:0]        r_last_grant;
  logic [GW-1:0]        w_last_grant_nxt;
  logic [GW-1:0]        w_arb_grant;
  logic                 w_arb_found;
  int unsigned          w_idx;

  logic                 w_out_free;
  logic                 w_accept;
  logic                 w_tlast_g;
  logic [ID_BITS-1:0]   w_tid_sel;

  logic [DATA_BITS-1:0] w_data [N_CHAN];
  logic [KEEP_BITS-1:0] w_keep [N_CHAN];
  logic [ID_BITS-1:0]   w_id   [N_CHAN];

  logic                 r_m_tvalid;
  logic [DATA_BITS-1:0] r_m_tdata;
  logic [KEEP_BITS-1:0] r_m_tkeep;
  logic                 r_m_tlast;
  logic [ID_BITS-1:0]   r_m_tid;

  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_slice
    assign w_data[gi] = s_tdata[gi*DATA_BITS +: DATA_BITS];
    assign w_keep[gi] = s_tkeep[gi*KEEP_BITS +: KEEP_BITS];
    assign w_id[gi]   = s_tid[gi*ID_BITS +: ID_BITS];
  end

  if (TAG_SRC != 0) begin : g_tag_src
    assign w_tid_sel = ID_BITS'(r_grant);
  end else begin : g_tag_pass
    assign w_tid_sel = w_id[r_grant];
  end

  assign w_out_free = !r_m_tvalid || m_tready;
  assign w_tlast_g  = s_tlast[r_grant];
  assign w_accept   = (r_state == S_BUSY) && s_tvalid[r_grant] && w_out_free;

  // Round-robin search starting one past the last channel that completed a packet.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_grant = '0;
    w_idx       = 0;
    for (int unsigned k = 1; k <= N_CHAN; k++) begin
      w_idx = (32'(r_last_grant) + k) % N_CHAN;
      if (!w_arb_found && s_tvalid[GW'(w_idx)]) begin
        w_arb_found = 1'b1;
        w_arb_grant = GW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    s_tready         = '0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_grant_nxt = w_arb_grant;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        s_tready[r_grant] = w_out_free;
        if (w_accept && w_tlast_g) begin
          w_last_grant_nxt = r_grant;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(LAST_CH);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Output skid-free register: load on accept, drain when consumed without a new load.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_data[r_grant];
      r_m_tkeep  <= w_keep[r_grant];
      r_m_tlast  <= w_tlast_g;
      r_m_tid    <= w_tid_sel;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tkeep  = r_m_tkeep;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;

`ifdef AXISR_RR_MUX_STATS_EN
  logic [31:0] r_pkt_cnt  [N_CHAN];
  logic [31:0] r_beat_cnt [N_CHAN];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        r_pkt_cnt[i]  <= '0;
        r_beat_cnt[i] <= '0;
      end
    end else if (w_accept) begin
      r_beat_cnt[r_grant] <= r_beat_cnt[r_grant] + 32'd1;
      if (w_tlast_g) begin
        r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
      end
    end
  end

  for (genvar gs = 0; gs < N_CHAN; gs++) begin : g_stat
    assign stat_pkt_cnt[gs*32 +: 32]  = r_pkt_cnt[gs];
    assign stat_beat_cnt[gs*32 +: 32] = r_beat_cnt[gs];
  end
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_axisr_rr_mux.sv
// Directed self-checking bench for axisr_rr_mux (4 channels, 32-bit data, source tagging on tid).
// Stats checks are compiled in when AXISR_RR_MUX_STATS_EN is defined.
module tb_axisr_rr_mux;

  localparam int unsigned NC = 4;
  localparam int unsigned DB = 32;
  localparam int unsigned KB = DB / 8;
  localparam int unsigned IB = 6;

  logic              clk;
  logic              aresetn;
  logic [NC-1:0]     s_tvalid;
  logic [NC-1:0]     s_tready;
  logic [NC*DB-1:0]  s_tdata;
  logic [NC*KB-1:0]  s_tkeep;
  logic [NC-1:0]     s_tlast;
  logic [NC*IB-1:0]  s_tid;
  logic              m_tvalid;
  logic              m_tready;
  logic [DB-1:0]     m_tdata;
  logic [KB-1:0]     m_tkeep;
  logic              m_tlast;
  logic [IB-1:0]     m_tid;
`ifdef AXISR_RR_MUX_STATS_EN
  logic [NC*32-1:0]  stat_pkt_cnt;
  logic [NC*32-1:0]  stat_beat_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  axisr_rr_mux #(
    .N_CHAN   (NC),
    .DATA_BITS(DB),
    .ID_BITS  (IB),
    .TAG_SRC  (1)
  ) u_dut (
    .aclk    (clk),
    .aresetn (aresetn),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tid   (s_tid),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tid   (m_tid)
`ifdef AXISR_RR_MUX_STATS_EN
    ,
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_beat_cnt(stat_beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source tid is deliberately different from the channel index so tagging is observable.
  task automatic set_ch(input int ch, input logic v, input logic [DB-1:0] d, input logic l);
    s_tvalid[ch]            = v;
    s_tdata[ch*DB +: DB]    = d;
    s_tkeep[ch*KB +: KB]    = {KB{1'b1}};
    s_tlast[ch]             = l;
    s_tid[ch*IB +: IB]      = IB'(32 + ch);
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    s_tid    = '0;
    m_tready = 1'b0;
    repeat (2) tick();
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
    vectors++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready got %b want 0000", s_tready); end
    vectors++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_m_tdata got %h want 0", m_tdata); end
    vectors++; if (m_tid !== 6'h0 || m_tlast !== 1'b0 || m_tkeep !== 4'h0) begin
      errors++; $display("FAIL reset_m_side got tid=%h last=%b keep=%h want 0/0/0", m_tid, m_tlast, m_tkeep);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_rr_order();
    int ch;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 32'hA0 + 32'(i), 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      vectors++;
      if (m_tvalid !== ((k % 2) == 0)) begin
        errors++; $display("FAIL rr_order_valid cycle=%0d got %b want %b", k, m_tvalid, (k % 2) == 0);
      end
      if ((k % 2) == 0) begin
        ch = k / 2 - 1;
        vectors++;
        if (m_tdata !== 32'hA0 + 32'(ch) || m_tid !== IB'(ch) || m_tlast !== 1'b1 || m_tkeep !== 4'hF) begin
          errors++;
          $display("FAIL rr_order_beat cycle=%0d got data=%h tid=%0d last=%b keep=%h want data=%h tid=%0d last=1 keep=f",
                   k, m_tdata, m_tid, m_tlast, m_tkeep, 32'hA0 + 32'(ch), ch);
        end
        set_ch(ch, 1'b0, '0, 1'b0);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [NC-1:0] exp_rdy;
    m_tready = 1'b1;
    set_ch(1, 1'b1, 32'h11, 1'b0);
    tick();
    vectors++; if (s_tready !== 4'b0010) begin errors++; $display("FAIL lock_first_ready got %b want 0010", s_tready); end
    for (int b = 0; b < 4; b++) begin
      tick();
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h11 + 32'(b) || m_tid !== 6'd1 || m_tlast !== (b == 3)) begin
        errors++;
        $display("FAIL lock_beat b=%0d got v=%b data=%h tid=%0d last=%b want v=1 data=%h tid=1 last=%b",
                 b, m_tvalid, m_tdata, m_tid, m_tlast, 32'h11 + 32'(b), b == 3);
      end
      if (b == 0) set_ch(2, 1'b1, 32'h22, 1'b1);
      if (b < 3) set_ch(1, 1'b1, 32'h11 + 32'(b + 1), (b + 1) == 3);
      else       set_ch(1, 1'b0, '0, 1'b0);
      exp_rdy = (b < 3) ? 4'b0010 : 4'b0000;
      vectors++;
      if (s_tready !== exp_rdy) begin errors++; $display("FAIL lock_ready b=%0d got %b want %b", b, s_tready, exp_rdy); end
    end
    tick();
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL lock_gap got m_tvalid=%b want 0", m_tvalid); end
    tick();
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h22 || m_tid !== 6'd2) begin
      errors++; $display("FAIL lock_ch2 got v=%b data=%h tid=%0d want v=1 data=22 tid=2", m_tvalid, m_tdata, m_tid);
    end
    set_ch(2, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_stall();
    bit [0:11]     pat = 12'b1110_0111_1111;
    int            nin = 0;
    int            nout = 0;
    logic          in_acc, out_acc, prev_stall;
    logic [DB-1:0] smp_data, held_data;
    logic [IB-1:0] smp_tid, held_tid;
    logic          smp_last, held_last;
    prev_stall = 1'b0;
    held_data = '0; held_tid = '0; held_last = 1'b0;
    set_ch(0, 1'b1, 32'h30, 1'b0);
    m_tready = pat[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_acc   = s_tvalid[0] && s_tready[0];
      out_acc  = m_tvalid && m_tready;
      smp_data = m_tdata; smp_tid = m_tid; smp_last = m_tlast;
      if (prev_stall) begin
        vectors++;
        if (m_tvalid !== 1'b1 || smp_data !== held_data || smp_tid !== held_tid || smp_last !== held_last) begin
          errors++;
          $display("FAIL stall_hold c=%0d got v=%b data=%h tid=%0d last=%b want v=1 data=%h tid=%0d last=%b",
                   c, m_tvalid, smp_data, smp_tid, smp_last, held_data, held_tid, held_last);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      held_data = smp_data; held_tid = smp_tid; held_last = smp_last;
      @(posedge clk);
      #1;
      if (in_acc) begin
        nin++;
        set_ch(0, nin < 4, 32'h30 + 32'(nin), nin == 3);
      end
      if (out_acc) begin
        vectors++;
        if (smp_data !== 32'h30 + 32'(nout) || smp_tid !== 6'd0 || smp_last !== (nout == 3)) begin
          errors++;
          $display("FAIL stall_beat n=%0d got data=%h tid=%0d last=%b want data=%h tid=0 last=%b",
                   nout, smp_data, smp_tid, smp_last, 32'h30 + 32'(nout), nout == 3);
        end
        nout++;
      end
      if (c < 11) m_tready = pat[c + 1];
    end
    m_tready = 1'b1;
    vectors++;
    if (nin !== 4 || nout !== 4) begin
      errors++; $display("FAIL stall_count got in=%0d out=%0d want in=4 out=4", nin, nout);
    end
    tick();
  endtask

  task automatic test_wrap();
    m_tready = 1'b1;
    set_ch(3, 1'b1, 32'h53, 1'b1);
    repeat (2) tick();
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h53 || m_tid !== 6'd3) begin
      errors++; $display("FAIL wrap_ch3 got v=%b data=%h tid=%0d want v=1 data=53 tid=3", m_tvalid, m_tdata, m_tid);
    end
    set_ch(3, 1'b1, 32'h43, 1'b1);
    set_ch(0, 1'b1, 32'h40, 1'b1);
    tick();
    tick();
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h40 || m_tid !== 6'd0) begin
      errors++; $display("FAIL wrap_ch0_first got v=%b data=%h tid=%0d want v=1 data=40 tid=0", m_tvalid, m_tdata, m_tid);
    end
    set_ch(0, 1'b0, '0, 1'b0);
    tick();
    tick();
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h43 || m_tid !== 6'd3) begin
      errors++; $display("FAIL wrap_ch3_second got v=%b data=%h tid=%0d want v=1 data=43 tid=3", m_tvalid, m_tdata, m_tid);
    end
    set_ch(3, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b1;
    set_ch(1, 1'b1, 32'h51, 1'b1);
    repeat (2) tick();
    vectors++;
    if (m_tdata !== 32'h51 || m_tid !== 6'd1) begin
      errors++; $display("FAIL rstmid_ch1 got data=%h tid=%0d want data=51 tid=1", m_tdata, m_tid);
    end
    set_ch(1, 1'b0, '0, 1'b0);
    set_ch(2, 1'b1, 32'h60, 1'b0);
    repeat (2) tick();
    set_ch(2, 1'b1, 32'h61, 1'b0);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h60 || s_tready !== 4'b0100) begin
      errors++; $display("FAIL rstmid_pre got v=%b data=%h rdy=%b want v=1 data=60 rdy=0100", m_tvalid, m_tdata, s_tready);
    end
    #2 aresetn = 1'b0;
    #1;
    vectors++;
    if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || m_tdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_async got v=%b rdy=%b data=%h want v=0 rdy=0000 data=0", m_tvalid, s_tready, m_tdata);
    end
    @(posedge clk);
    #3;
    aresetn = 1'b1;
    set_ch(0, 1'b1, 32'h70, 1'b1);
    set_ch(2, 1'b1, 32'h72, 1'b1);
    set_ch(3, 1'b1, 32'h73, 1'b1);
    tick();
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_bubble got m_tvalid=%b want 0", m_tvalid); end
    for (int j = 0; j < 3; j++) begin
      int ch;
      ch = (j == 0) ? 0 : j + 1;
      if (j > 0) tick();
      tick();
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h70 + 32'(ch) || m_tid !== IB'(ch)) begin
        errors++;
        $display("FAIL rstmid_order j=%0d got v=%b data=%h tid=%0d want v=1 data=%h tid=%0d",
                 j, m_tvalid, m_tdata, m_tid, 32'h70 + 32'(ch), ch);
      end
      set_ch(ch, 1'b0, '0, 1'b0);
    end
    tick();
  endtask

`ifdef AXISR_RR_MUX_STATS_EN
  task automatic test_stats();
    int   n = 0;
    logic in_acc;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    vectors++;
    if (stat_pkt_cnt !== '0 || stat_beat_cnt !== '0) begin
      errors++; $display("FAIL stats_reset got pkt=%h beat=%h want 0", stat_pkt_cnt, stat_beat_cnt);
    end
    m_tready = 1'b1;
    set_ch(1, 1'b1, 32'h100, 1'b0);
    for (int c = 0; c < 40 && n < 15; c++) begin
      @(negedge clk);
      in_acc = s_tvalid[1] && s_tready[1];
      @(posedge clk);
      #1;
      if (in_acc) begin
        n++;
        set_ch(1, n < 15, 32'h100 + 32'(n), (n % 5) == 4);
      end
    end
    vectors++;
    if (n !== 15) begin errors++; $display("FAIL stats_beats_sent got %0d want 15", n); end
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (stat_pkt_cnt[i*32 +: 32] !== ((i == 1) ? 32'd3 : 32'd0) ||
          stat_beat_cnt[i*32 +: 32] !== ((i == 1) ? 32'd15 : 32'd0)) begin
        errors++;
        $display("FAIL stats_ch%0d got pkt=%0d beat=%0d want pkt=%0d beat=%0d", i,
                 stat_pkt_cnt[i*32 +: 32], stat_beat_cnt[i*32 +: 32], (i == 1) ? 3 : 0, (i == 1) ? 15 : 0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_order();
    test_packet_lock();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef AXISR_RR_MUX_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
